// File: rtl/qif_pkg.sv
// Shared constants, widths and FSM encoding for the QIF neuron datapath and
// the time-multiplexed scheduler built around it.
package qif_pkg;

  localparam int V_W   = 8;   // membrane width (signed)
  localparam int I_W   = 8;   // current / bias width (unsigned)
  localparam int SUM_W = 11;  // headroom for v + a + q*q before saturation
  localparam int REF_W = 4;   // refractory counter width

  localparam logic signed [V_W-1:0] DEF_V_TH         = 8'sd50;
  localparam logic signed [V_W-1:0] DEF_V_RESET      = -8'sd20;
  localparam logic [REF_W-1:0]      DEF_REFRAC_TICKS = 4'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_COMPUTE,
    S_WRITEBACK
  } state_t;

endpackage

// File: rtl/qif_update_unit.sv
// Combinational QIF membrane update for one neuron: quadratic growth term,
// saturation, threshold/spike and refractory handling.
module qif_update_unit
  import qif_pkg::*;
#(
  parameter logic signed [V_W-1:0] V_TH         = DEF_V_TH,
  parameter logic signed [V_W-1:0] V_RESET      = DEF_V_RESET,
  parameter logic [REF_W-1:0]      REFRAC_TICKS = DEF_REFRAC_TICKS
) (
  input  logic signed [V_W-1:0] v,
  input  logic [I_W-1:0]        i_eff,
  input  logic [REF_W-1:0]      refrac,
  output logic signed [V_W-1:0] v_next,
  output logic [REF_W-1:0]      refrac_next,
  output logic                  spike
);

  localparam logic signed [SUM_W-1:0] S_MAX = 127;
  localparam logic signed [SUM_W-1:0] S_MIN = -128;

  logic signed [V_W-1:0]   q;
  logic signed [SUM_W-1:0] v_ext;
  logic signed [SUM_W-1:0] a_ext;
  logic signed [SUM_W-1:0] q_ext;
  logic signed [SUM_W-1:0] s_raw;
  logic signed [V_W-1:0]   s_sat;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    q     = v >>> 3;
    v_ext = {{(SUM_W-V_W){v[V_W-1]}}, v};
    a_ext = {{(SUM_W-I_W){1'b0}}, (i_eff >> 2)};
    q_ext = {{(SUM_W-V_W){q[V_W-1]}}, q};
    s_raw = v_ext + a_ext + q_ext * q_ext;

    if (s_raw > S_MAX)      s_sat = S_MAX[V_W-1:0];
    else if (s_raw < S_MIN) s_sat = S_MIN[V_W-1:0];
    else                    s_sat = s_raw[V_W-1:0];

    v_next      = s_sat;
    refrac_next = refrac;
    spike       = 1'b0;

    if (refrac != '0) begin
      v_next      = V_RESET;
      refrac_next = refrac - 1'b1;
    end else if (s_sat >= V_TH) begin
      v_next      = V_RESET;
      refrac_next = REFRAC_TICKS;
      spike       = 1'b1;
    end
  end

endmodule

// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexes one QIF update unit across N_NEURONS virtual neurons,
// one fetch/compute/writeback slot per neuron per divider tick.
module qif_neuron_scheduler
  import qif_pkg::*;
#(
  parameter int                    N_NEURONS    = 4,
  parameter logic signed [V_W-1:0] V_TH         = DEF_V_TH,
  parameter logic signed [V_W-1:0] V_RESET      = DEF_V_RESET,
  parameter logic [REF_W-1:0]      REFRAC_TICKS = DEF_REFRAC_TICKS,
  parameter int                    TICK_DIV     = 16,
  localparam int                   A_W          = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int                   C_W          = $clog2(TICK_DIV)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [I_W-1:0]        i_syn,
  input  logic                  cfg_we,
  input  logic [A_W-1:0]        cfg_addr,
  input  logic [I_W-1:0]        cfg_data,
  output logic                  cfg_ack,
  input  logic [A_W-1:0]        mon_sel,
  output logic signed [V_W-1:0] v_mon,
  output logic [N_NEURONS-1:0]  spike_vec,
  output logic                  round_done,
  output logic                  busy,
  output logic                  overrun
);

  state_t state, state_nxt;
  logic [C_W-1:0] div_cnt;
  logic [A_W-1:0] k;

  logic signed [V_W-1:0] v_mem    [N_NEURONS];
  logic [I_W-1:0]        bias_mem [N_NEURONS];
  logic [REF_W-1:0]      ref_mem  [N_NEURONS];

  logic signed [V_W-1:0] v_lat, v_res, v_upd;
  logic [I_W-1:0]        bias_lat;
  logic [REF_W-1:0]      ref_lat, ref_res, ref_upd;
  logic                  spk_res, spk_upd;
  logic [I_W:0]          i_sum;
  logic [I_W-1:0]        i_eff;

  logic tick, last, round_start, wb_last, cfg_ok;

  assign tick   = ena && (div_cnt == C_W'(TICK_DIV - 1));
  assign last   = (k == A_W'(N_NEURONS - 1));
  assign cfg_ok = cfg_we && (state == S_IDLE) && !tick;
  assign busy   = (state != S_IDLE);

  // Bias is added to the live shared current and clamped before the >>2.
  assign i_sum = {1'b0, i_syn} + {1'b0, bias_lat};
  assign i_eff = i_sum[I_W] ? '1 : i_sum[I_W-1:0];

  qif_update_unit #(
    .V_TH         (V_TH),
    .V_RESET      (V_RESET),
    .REFRAC_TICKS (REFRAC_TICKS)
  ) u_update (
    .v           (v_lat),
    .i_eff       (i_eff),
    .refrac      (ref_lat),
    .v_next      (v_upd),
    .refrac_next (ref_upd),
    .spike       (spk_upd)
  );

  always_comb begin
    state_nxt   = state;
    round_start = 1'b0;
    wb_last     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick) begin
          state_nxt   = S_FETCH;
          round_start = 1'b1;
        end
      end
      S_FETCH:   state_nxt = S_COMPUTE;
      S_COMPUTE: state_nxt = S_WRITEBACK;
      S_WRITEBACK: begin
        if (last) begin
          state_nxt = S_IDLE;
          wb_last   = 1'b1;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      if (round_start)                         k <= '0;
      else if (state == S_WRITEBACK && !last)  k <= k + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (ena) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_lat    <= '0;
      bias_lat <= '0;
      ref_lat  <= '0;
      v_res    <= '0;
      ref_res  <= '0;
      spk_res  <= 1'b0;
    end else begin
      if (state == S_FETCH) begin
        v_lat    <= v_mem[k];
        bias_lat <= bias_mem[k];
        ref_lat  <= ref_mem[k];
      end
      if (state == S_COMPUTE) begin
        v_res   <= v_upd;
        ref_res <= ref_upd;
        spk_res <= spk_upd;
      end
    end
  end

  // NOTE: the neuron state arrays are cleared by reset because a fresh tile
  // must start every membrane, bias and refractory count at zero; this keeps
  // them in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]   <= '0;
        ref_mem[i] <= '0;
      end
    end else if (state == S_WRITEBACK) begin
      v_mem[k]   <= v_res;
      ref_mem[k] <= ref_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) bias_mem[i] <= '0;
    end else if (cfg_ok) begin
      bias_mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_vec  <= '0;
      round_done <= 1'b0;
      cfg_ack    <= 1'b0;
      overrun    <= 1'b0;
      v_mon      <= '0;
    end else begin
      if (round_start)                spike_vec    <= '0;
      else if (state == S_WRITEBACK)  spike_vec[k] <= spk_res;
      round_done <= wb_last;
      cfg_ack    <= cfg_ok;
      if (tick && state != S_IDLE) overrun <= 1'b1;
      v_mon      <= v_mem[mon_sel];
    end
  end

endmodule
